// File: rtl/pu_bus_pkg.sv
// ---------------------------------------------------------------------------
// pu_bus_pkg
// Shared definitions for the processing-unit (PU) bus initiator.
//   state_t      : driver FSM states
//   dbg_t        : debug snapshot exported by the driver
//   DEF_*        : default bus widths
//   INVALID_BIT  : default attribute bit index flagging an invalid value
//   LAT_CNT_W    : width of the PU latency wait counter
//   sat_inc16()  : saturating 16-bit increment used by the statistics block
// ---------------------------------------------------------------------------
package pu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR_A = 3'd1,
        WR_B = 3'd2,
        WAIT = 3'd3,
        READ = 3'd4,
        HOLD = 3'd5
    } state_t;

    typedef struct packed {
        state_t state;
        logic   cnt_zero;
        logic   res_invalid;
    } dbg_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ATTR_WIDTH = 4;
    localparam int INVALID_BIT    = 0;
    localparam int LAT_CNT_W      = 4;
    localparam int STAT_W         = 16;

    function automatic logic [STAT_W-1:0] sat_inc16(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pu_driver_latency_counter.sv
// ---------------------------------------------------------------------------
// pu_driver_latency_counter
// Loadable down-counter with a zero flag; times the idle gap between the
// second operand write and the result read.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (count -> 0)
//   i_load         : load i_load_val (has priority over i_dec)
//   i_load_val     : value to load
//   i_dec          : decrement by one; holds at zero
//   o_zero         : count is zero
// ---------------------------------------------------------------------------
module pu_driver_latency_counter
    import pu_bus_pkg::*;
#(
    parameter int W = LAT_CNT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/pu_multiplier_driver.sv
// ---------------------------------------------------------------------------
// pu_multiplier_driver
// Initiator for the PU bus: takes an operand pair from a command port,
// writes operand A then operand B into the PU (signal_wr), waits PU_LATENCY
// idle cycles, reads the result with a one-cycle signal_oe pulse and offers
// it on a result port until the consumer takes it.
//
// Ports
//   clk, rst                      : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake
//   cmd_a, cmd_a_attr             : first operand and its attributes
//   cmd_b, cmd_b_attr             : second operand and its attributes
//   signal_wr, signal_oe          : PU write strobe / output enable
//   data_to_pu, attr_to_pu        : PU data_in / attr_in (0 while wr low)
//   data_from_pu, attr_from_pu    : PU data_out / attr_out
//   res_valid/res_ready           : result handshake
//   res_data, res_attr            : captured result
//   busy                          : high in every state except IDLE
//   stat_count, stat_invalid      : handshake counters (PU_DRIVER_STATS_EN)
//   o_dbg                         : FSM state, counter zero flag, result
//                                   invalid flag
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A producer keeps valid and its payload steady until that
// edge; ready may change freely. cmd_ready is only high in IDLE, so a
// command offered while busy simply waits.
//
// Build option: define PU_DRIVER_STATS_EN to add saturating 16-bit
// counters of result handshakes and of results flagged invalid.
// ---------------------------------------------------------------------------
module pu_multiplier_driver
    import pu_bus_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ATTR_WIDTH = DEF_ATTR_WIDTH,
    parameter int INVALID    = INVALID_BIT,
    parameter int PU_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [ATTR_WIDTH-1:0] cmd_a_attr,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic [ATTR_WIDTH-1:0] cmd_b_attr,
    output logic                  signal_wr,
    output logic                  signal_oe,
    output logic [DATA_WIDTH-1:0] data_to_pu,
    output logic [ATTR_WIDTH-1:0] attr_to_pu,
    input  logic [DATA_WIDTH-1:0] data_from_pu,
    input  logic [ATTR_WIDTH-1:0] attr_from_pu,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [ATTR_WIDTH-1:0] res_attr,
    output logic                  busy,
`ifdef PU_DRIVER_STATS_EN
    output logic [STAT_W-1:0]     stat_count,
    output logic [STAT_W-1:0]     stat_invalid,
`endif
    output dbg_t                  o_dbg
);

    // Counter is loaded with PU_LATENCY-1 while entering WAIT, so WAIT
    // lasts exactly PU_LATENCY cycles.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (PU_LATENCY > 0) ? LAT_CNT_W'(PU_LATENCY - 1) : '0;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_signal_wr;
    logic                  r_signal_oe;
    logic [DATA_WIDTH-1:0] r_data_to_pu;
    logic [ATTR_WIDTH-1:0] r_attr_to_pu;
    logic                  r_res_valid;
    logic [DATA_WIDTH-1:0] r_res_data;
    logic [ATTR_WIDTH-1:0] r_res_attr;
    logic                  r_busy;
    // Operand A goes straight into the bus register on accept; only B
    // needs to be held for the following cycle.
    logic [DATA_WIDTH-1:0] r_b;
    logic [ATTR_WIDTH-1:0] r_b_attr;

    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_zero;

    assign w_cnt_load = (r_state == WR_B) && (PU_LATENCY != 0);
    assign w_cnt_dec  = (r_state == WAIT) && !w_cnt_zero;

    pu_driver_latency_counter #(
        .W (LAT_CNT_W)
    ) u_lat_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    // Outputs are registered alongside the state: each branch sets the
    // values that belong to the state being entered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cmd_ready  <= 1'b1;
            r_signal_wr  <= 1'b0;
            r_signal_oe  <= 1'b0;
            r_data_to_pu <= '0;
            r_attr_to_pu <= '0;
            r_res_valid  <= 1'b0;
            r_res_data   <= '0;
            r_res_attr   <= '0;
            r_busy       <= 1'b0;
            r_b          <= '0;
            r_b_attr     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid) begin
                        r_b          <= cmd_b;
                        r_b_attr     <= cmd_b_attr;
                        r_data_to_pu <= cmd_a;
                        r_attr_to_pu <= cmd_a_attr;
                        r_signal_wr  <= 1'b1;
                        r_cmd_ready  <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= WR_A;
                    end
                end
                WR_A: begin
                    r_data_to_pu <= r_b;
                    r_attr_to_pu <= r_b_attr;
                    r_state      <= WR_B;
                end
                WR_B: begin
                    r_signal_wr  <= 1'b0;
                    r_data_to_pu <= '0;
                    r_attr_to_pu <= '0;
                    if (PU_LATENCY == 0) begin
                        r_signal_oe <= 1'b1;
                        r_state     <= READ;
                    end else begin
                        r_state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_cnt_zero) begin
                        r_signal_oe <= 1'b1;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_signal_oe <= 1'b0;
                    r_res_data  <= data_from_pu;
                    r_res_attr  <= attr_from_pu;
                    r_res_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_signal_wr  <= 1'b0;
                    r_signal_oe  <= 1'b0;
                    r_data_to_pu <= '0;
                    r_attr_to_pu <= '0;
                    r_res_valid  <= 1'b0;
                    r_cmd_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign signal_wr  = r_signal_wr;
    assign signal_oe  = r_signal_oe;
    assign data_to_pu = r_data_to_pu;
    assign attr_to_pu = r_attr_to_pu;
    assign res_valid  = r_res_valid;
    assign res_data   = r_res_data;
    assign res_attr   = r_res_attr;
    assign busy       = r_busy;

    assign o_dbg.state       = r_state;
    assign o_dbg.cnt_zero    = w_cnt_zero;
    assign o_dbg.res_invalid = r_res_attr[INVALID];

`ifdef PU_DRIVER_STATS_EN
    logic [STAT_W-1:0] r_stat_count;
    logic [STAT_W-1:0] r_stat_invalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_count   <= '0;
            r_stat_invalid <= '0;
        end else if (r_res_valid && res_ready) begin
            r_stat_count <= sat_inc16(r_stat_count);
            if (r_res_attr[INVALID]) begin
                r_stat_invalid <= sat_inc16(r_stat_invalid);
            end
        end
    end

    assign stat_count   = r_stat_count;
    assign stat_invalid = r_stat_invalid;
`endif

endmodule

// File: tb/tb_pu_multiplier_driver.sv
// ---------------------------------------------------------------------------
// tb_pu_multiplier_driver
// Drives pu_multiplier_driver (PU_LATENCY=2) against a behavioural
// multiplier PU, plus a second instance built with PU_LATENCY=0.
// Expected results are queued when a command is accepted and compared when
// the result handshake occurs.
// ---------------------------------------------------------------------------
module tb_pu_multiplier_driver;
    import pu_bus_pkg::*;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (PU_LATENCY = 2) ----------------
    logic          cmd_valid, cmd_ready;
    logic [DW-1:0] cmd_a, cmd_b;
    logic [AW-1:0] cmd_a_attr, cmd_b_attr;
    logic          signal_wr, signal_oe;
    logic [DW-1:0] data_to_pu, data_from_pu;
    logic [AW-1:0] attr_to_pu, attr_from_pu;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic [AW-1:0] res_attr;
    logic          busy;
    dbg_t          dbg;
`ifdef PU_DRIVER_STATS_EN
    logic [15:0]   stat_count, stat_invalid;
`endif

    pu_multiplier_driver #(
        .DATA_WIDTH (DW), .ATTR_WIDTH (AW), .INVALID (0), .PU_LATENCY (LAT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a        (cmd_a),
        .cmd_a_attr   (cmd_a_attr),
        .cmd_b        (cmd_b),
        .cmd_b_attr   (cmd_b_attr),
        .signal_wr    (signal_wr),
        .signal_oe    (signal_oe),
        .data_to_pu   (data_to_pu),
        .attr_to_pu   (attr_to_pu),
        .data_from_pu (data_from_pu),
        .attr_from_pu (attr_from_pu),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_attr     (res_attr),
        .busy         (busy),
`ifdef PU_DRIVER_STATS_EN
        .stat_count   (stat_count),
        .stat_invalid (stat_invalid),
`endif
        .o_dbg        (dbg)
    );

    // ---------------- DUT (PU_LATENCY = 0) ----------------
    logic          z_cmd_valid, z_cmd_ready;
    logic [DW-1:0] z_cmd_a, z_cmd_b;
    logic          z_signal_wr, z_signal_oe;
    logic [DW-1:0] z_data_to_pu, z_data_from_pu;
    logic [AW-1:0] z_attr_to_pu, z_attr_from_pu;
    logic          z_res_valid, z_res_ready;
    logic [DW-1:0] z_res_data;
    logic [AW-1:0] z_res_attr;
    logic          z_busy;
    dbg_t          z_dbg;
`ifdef PU_DRIVER_STATS_EN
    logic [15:0]   z_stat_count, z_stat_invalid;
`endif

    pu_multiplier_driver #(
        .DATA_WIDTH (DW), .ATTR_WIDTH (AW), .INVALID (0), .PU_LATENCY (0)
    ) u_dut_z (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (z_cmd_valid),
        .cmd_ready    (z_cmd_ready),
        .cmd_a        (z_cmd_a),
        .cmd_a_attr   (4'h0),
        .cmd_b        (z_cmd_b),
        .cmd_b_attr   (4'h0),
        .signal_wr    (z_signal_wr),
        .signal_oe    (z_signal_oe),
        .data_to_pu   (z_data_to_pu),
        .attr_to_pu   (z_attr_to_pu),
        .data_from_pu (z_data_from_pu),
        .attr_from_pu (z_attr_from_pu),
        .res_valid    (z_res_valid),
        .res_ready    (z_res_ready),
        .res_data     (z_res_data),
        .res_attr     (z_res_attr),
        .busy         (z_busy),
`ifdef PU_DRIVER_STATS_EN
        .stat_count   (z_stat_count),
        .stat_invalid (z_stat_invalid),
`endif
        .o_dbg        (z_dbg)
    );

    // ---------------- behavioural multiplier PUs ----------------
    // First write captures A, second write stores A*B (low bits) and the OR
    // of both attribute words. Outputs are driven only while oe is high.
    logic          p_have, z_have;
    logic [DW-1:0] p_a, p_prod, z_a, z_prod;
    logic [AW-1:0] p_aa, p_pattr, z_aa, z_pattr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_have <= 1'b0; p_a <= '0; p_aa <= '0; p_prod <= '0; p_pattr <= '0;
        end else if (signal_wr) begin
            if (!p_have) begin
                p_have <= 1'b1; p_a <= data_to_pu; p_aa <= attr_to_pu;
            end else begin
                p_have <= 1'b0; p_prod <= p_a * data_to_pu; p_pattr <= p_aa | attr_to_pu;
            end
        end
    end
    assign data_from_pu = signal_oe ? p_prod : '0;
    assign attr_from_pu = signal_oe ? p_pattr : '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            z_have <= 1'b0; z_a <= '0; z_aa <= '0; z_prod <= '0; z_pattr <= '0;
        end else if (z_signal_wr) begin
            if (!z_have) begin
                z_have <= 1'b1; z_a <= z_data_to_pu; z_aa <= z_attr_to_pu;
            end else begin
                z_have <= 1'b0; z_prod <= z_a * z_data_to_pu; z_pattr <= z_aa | z_attr_to_pu;
            end
        end
    end
    assign z_data_from_pu = z_signal_oe ? z_prod : '0;
    assign z_attr_from_pu = z_signal_oe ? z_pattr : '0;

    // ---------------- scoreboard / checking ----------------
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_attr_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int n_wr = 0, n_oe = 0;
    int rise_cyc = 0, hs_cyc = 0;
    logic prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus monitor and result scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            prev_valid = 1'b0;
        end else begin
            if (signal_wr) n_wr++;
            if (signal_oe) n_oe++;
            chk("wr_oe_exclusive", 32'(signal_wr && signal_oe), 0);
            if (!signal_wr) begin
                chk("idle_bus_data", data_to_pu, 0);
                chk("idle_bus_attr", 32'(attr_to_pu), 0);
            end
            if (res_valid && !prev_valid) rise_cyc = cyc;
            prev_valid = res_valid;
            if (res_valid && res_ready) begin
                hs_cyc = cyc;
                chk("sb_result_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    chk("sb_res_data", res_data, exp_q.pop_front());
                    chk("sb_res_attr", 32'(res_attr), 32'(exp_attr_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [DW-1:0] a, input logic [AW-1:0] aa,
                            input logic [DW-1:0] b, input logic [AW-1:0] ba,
                            input logic [DW-1:0] ed, input logic [AW-1:0] ea,
                            output int acc);
        bit ok = 1'b0;
        acc = -1;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = a; cmd_a_attr = aa; cmd_b = b; cmd_b_attr = ba;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                acc = cyc;
                exp_q.push_back(ed);
                exp_attr_q.push_back(ea);
                break;
            end
        end
        chk("cmd_accepted", 32'(ok), 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_a_attr = '0; cmd_b = '0; cmd_b_attr = '0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk(tag, 32'(exp_q.size()), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_res_valid(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
        chk(tag, 32'(ok), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int acc1, acc2, w0, o0;
        bit ok;
        state_t st[4];

        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_a_attr = '0; cmd_b_attr = '0;
        res_ready = 1'b0;
        z_cmd_valid = 1'b0; z_cmd_a = '0; z_cmd_b = '0; z_res_ready = 1'b1;

        // reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_signal_wr", 32'(signal_wr), 0);
        chk("rst_signal_oe", 32'(signal_oe), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data_to_pu", data_to_pu, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_state", 32'(dbg.state), 32'(IDLE));
        @(posedge clk); #1;
        rst = 1'b1;

        // basic transaction: strobe counts and latency
        res_ready = 1'b1;
        w0 = n_wr; o0 = n_oe;
        send_cmd(32'd5, 4'h0, 32'h0010_0007, 4'h0, 32'h0050_0023, 4'h0, acc1);
        wait_drain("t1_drain");
        chk("t1_wr_cycles", 32'(n_wr - w0), 2);
        chk("t1_oe_pulses", 32'(n_oe - o0), 1);
        chk("t1_latency", 32'(rise_cyc - acc1), 4 + LAT);

        // negative operands, then back-to-back command
        send_cmd(32'hFFFF_FFF6, 4'h0, 32'hFFFF_FFF6, 4'h0, 32'd100, 4'h0, acc1);
        send_cmd(32'h111, 4'h0, 32'h111, 4'h0, 32'h0001_2321, 4'h0, acc2);
        chk("t2_ready_after_handshake", 32'(acc2 - hs_cyc), 1);
        chk("t2_throughput", 32'(acc2 - acc1), 5 + LAT);
        wait_drain("t2_drain");

        // invalid attribute propagates
        send_cmd(32'd4, 4'h1, 32'd5, 4'h0, 32'd20, 4'h1, acc1);
        wait_drain("t3_drain");
`ifdef PU_DRIVER_STATS_EN
        chk("t3_stat_count", 32'(stat_count), 4);
        chk("t3_stat_invalid", 32'(stat_invalid), 1);
`endif

        // back-pressure: result held 10 cycles, command ignored during HOLD
        @(posedge clk); #1;
        res_ready = 1'b0;
        send_cmd(32'hFFFF_FFFC, 4'h0, 32'd5, 4'h0, 32'hFFFF_FFEC, 4'h0, acc1);
        wait_res_valid("t4_res_valid_seen");
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_a = 32'd7; cmd_b = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(res_valid), 1);
            chk("t4_hold_data", res_data, 32'hFFFF_FFEC);
            chk("t4_hold_cmd_ready", 32'(cmd_ready), 0);
            chk("t4_hold_state", 32'(dbg.state), 32'(HOLD));
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
        res_ready = 1'b1;
        wait_drain("t4_drain");
        repeat (8) @(negedge clk);
        chk("t4_no_extra_txn", 32'(busy), 0);

        // asynchronous reset during WAIT
        send_cmd(32'd6, 4'h0, 32'd7, 4'h0, 32'd42, 4'h0, acc1);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (dbg.state == WAIT) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("t5_reached_wait", 32'(ok), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_signal_wr", 32'(signal_wr), 0);
        chk("t5_rst_signal_oe", 32'(signal_oe), 0);
        chk("t5_rst_res_valid", 32'(res_valid), 0);
        chk("t5_rst_res_data", res_data, 0);
        chk("t5_rst_state", 32'(dbg.state), 32'(IDLE));
`ifdef PU_DRIVER_STATS_EN
        chk("t5_rst_stat_count", 32'(stat_count), 0);
`endif
        exp_q.delete();
        exp_attr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        send_cmd(32'd4, 4'h0, 32'd5, 4'h0, 32'd20, 4'h0, acc1);
        wait_drain("t5_drain");

        // PU_LATENCY = 0 instance: READ directly after WR_B
        @(posedge clk); #1;
        z_cmd_valid = 1'b1; z_cmd_a = 32'd3; z_cmd_b = 32'd7;
        @(negedge clk);
        chk("t6_cmd_ready", 32'(z_cmd_ready), 1);
        @(posedge clk); #1;
        z_cmd_valid = 1'b0; z_cmd_a = '0; z_cmd_b = '0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            else #4;
            st[i] = z_dbg.state;
        end
        chk("t6_state1", 32'(st[0]), 32'(WR_A));
        chk("t6_state2", 32'(st[1]), 32'(WR_B));
        chk("t6_state3", 32'(st[2]), 32'(READ));
        chk("t6_state4", 32'(st[3]), 32'(HOLD));
        chk("t6_res_valid", 32'(z_res_valid), 1);
        chk("t6_res_data", z_res_data, 32'd21);
        repeat (2) @(negedge clk);
        chk("t6_back_idle", 32'(z_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
